// File: rtl/qracc_pkg.sv
// qracc_pkg: shared state encoding, job configuration record and default widths for the QRAcc data master
package qracc_pkg;

    localparam int QRACC_DATA_W = 32;
    localparam int QRACC_ADDR_W = 16;
    localparam int QRACC_LEN_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WEIGHTS = 3'd1,
        S_ACTS    = 3'd2,
        S_SCALERS = 3'd3,
        S_OUTPUTS = 3'd4,
        S_DONE    = 3'd5
    } master_state_t;

    typedef struct packed {
        logic [QRACC_ADDR_W-1:0] src_base;
        logic [QRACC_ADDR_W-1:0] dst_base;
        logic [QRACC_LEN_W-1:0]  n_weight;
        logic [QRACC_LEN_W-1:0]  n_act;
        logic [QRACC_LEN_W-1:0]  n_scaler;
        logic [QRACC_LEN_W-1:0]  n_out;
    } qracc_master_cfg_t;

    function automatic logic is_send_state(input master_state_t s);
        return s inside {S_WEIGHTS, S_ACTS, S_SCALERS};
    endfunction

endpackage

// File: rtl/qracc_word_fifo.sv
// qracc_word_fifo: synchronous power-of-two FIFO with occupancy count and synchronous flush
module qracc_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == FULL_C;
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next storage/pointer/count; flush wins over any same-cycle push or pop
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/qracc_data_master.sv
// qracc_data_master: streams weights/acts/scalers from memory to the QRAcc bus, then drains outputs back to memory.
// Optional QRACC_DATA_MASTER_PERF_EN adds saturating bus-stall and FIFO-starvation counters.
module qracc_data_master
    import qracc_pkg::*;
#(
    parameter int dataBusWidth = QRACC_DATA_W,
    parameter int memAddrWidth = QRACC_ADDR_W,
    parameter int lenWidth     = QRACC_LEN_W,
    parameter int fifoDepth    = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start_i,
    input  logic                    clear_i,
    input  logic [memAddrWidth-1:0] src_base_i,
    input  logic [memAddrWidth-1:0] dst_base_i,
    input  logic [lenWidth-1:0]     n_weight_i,
    input  logic [lenWidth-1:0]     n_act_i,
    input  logic [lenWidth-1:0]     n_scaler_i,
    input  logic [lenWidth-1:0]     n_out_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    mem_rq_valid_o,
    input  logic                    mem_rq_ready_i,
    output logic [memAddrWidth-1:0] mem_rq_addr_o,
    input  logic [dataBusWidth-1:0] mem_rd_data_i,
    input  logic                    mem_rd_valid_i,
    output logic                    mem_wr_en_o,
    output logic [memAddrWidth-1:0] mem_wr_addr_o,
    output logic [dataBusWidth-1:0] mem_wr_data_o,
    output logic                    bus_valid_o,
    input  logic                    bus_ready_i,
    output logic                    bus_wen_o,
    output logic [dataBusWidth-1:0] bus_data_o,
    input  logic [dataBusWidth-1:0] bus_rd_data_i,
    input  logic                    bus_rd_data_valid_i
`ifdef QRACC_DATA_MASTER_PERF_EN
    ,
    output logic [31:0]             perf_bus_stall_o,
    output logic [31:0]             perf_fifo_empty_o
`endif
);

    localparam int CW = $clog2(fifoDepth) + 1;
    localparam logic [CW-1:0] DEPTH_C = fifoDepth[CW-1:0];

    master_state_t            state_q, state_d;
    qracc_master_cfg_t        cfg_q, cfg_d;
    logic [memAddrWidth-1:0]  word_idx_q, word_idx_d;
    logic [lenWidth-1:0]      fetched_q, fetched_d, sent_q, sent_d, received_q, received_d;
    logic                     inflight_q, inflight_d, drop_q, drop_d;

    logic                     send_phase, rq_fire, push, pop, phase_end, rd_take, out_end;
    logic [lenWidth-1:0]      phase_len;
    master_state_t            next_phase;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_full, fifo_empty;
    logic [dataBusWidth-1:0]  fifo_head;

    assign send_phase = is_send_state(state_q);
    assign phase_len  = state_q == S_WEIGHTS ? cfg_q.n_weight :
                        state_q == S_ACTS    ? cfg_q.n_act    : cfg_q.n_scaler;
    assign next_phase = state_q == S_WEIGHTS ? S_ACTS :
                        state_q == S_ACTS    ? S_SCALERS : S_OUTPUTS;

    // Prefetch only while the FIFO plus the one possible in-flight word still fits
    assign mem_rq_valid_o = send_phase && !fifo_full && fetched_q < phase_len
                            && (fifo_count + {{(CW-1){1'b0}}, inflight_q}) < DEPTH_C;
    assign mem_rq_addr_o  = mem_rq_valid_o ? cfg_q.src_base + word_idx_q : '0;
    assign rq_fire        = mem_rq_valid_o && mem_rq_ready_i;
    assign push           = mem_rd_valid_i && inflight_q && !drop_q;

    assign bus_wen_o   = send_phase && !fifo_empty;
    assign bus_valid_o = bus_wen_o || (state_q == S_OUTPUTS && received_q < cfg_q.n_out);
    assign bus_data_o  = bus_wen_o ? fifo_head : '0;
    assign pop         = bus_wen_o && bus_ready_i;
    assign phase_end   = phase_len == '0 || (pop && sent_q == phase_len - 1'b1);

    assign rd_take       = state_q == S_OUTPUTS && bus_rd_data_valid_i && received_q < cfg_q.n_out;
    assign out_end       = cfg_q.n_out == '0 || (rd_take && received_q == cfg_q.n_out - 1'b1);
    assign mem_wr_en_o   = rd_take;
    assign mem_wr_addr_o = rd_take ? cfg_q.dst_base + memAddrWidth'(received_q) : '0;
    assign mem_wr_data_o = rd_take ? bus_rd_data_i : '0;

    assign busy_o = state_q != S_IDLE;
    assign done_o = state_q == S_DONE;

    qracc_word_fifo #(
        .WIDTH (dataBusWidth),
        .DEPTH (fifoDepth)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (clear_i),
        .push      (push),
        .push_data (mem_rd_data_i),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Job sequencing: config latch, per-phase fetch/send counters, output drain, abort
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        word_idx_d = word_idx_q;
        fetched_d  = fetched_q;
        sent_d     = sent_q;
        received_d = received_q;
        inflight_d = rq_fire;
        drop_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cfg_d = '{src_base: src_base_i, dst_base: dst_base_i, n_weight: n_weight_i,
                              n_act: n_act_i, n_scaler: n_scaler_i, n_out: n_out_i};
                    state_d    = S_WEIGHTS;
                    word_idx_d = '0;
                    fetched_d  = '0;
                    sent_d     = '0;
                    received_d = '0;
                end
            end
            S_WEIGHTS, S_ACTS, S_SCALERS: begin
                if (rq_fire) begin
                    fetched_d  = fetched_q + 1'b1;
                    word_idx_d = word_idx_q + 1'b1;
                end
                if (pop) sent_d = sent_q + 1'b1;
                if (phase_end) begin
                    state_d   = next_phase;
                    fetched_d = '0;
                    sent_d    = '0;
                end
            end
            S_OUTPUTS: begin
                if (rd_take) received_d = received_q + 1'b1;
                if (out_end) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_i) begin
            state_d    = S_IDLE;
            word_idx_d = '0;
            fetched_d  = '0;
            sent_d     = '0;
            received_d = '0;
            inflight_d = 1'b0;
            drop_d     = rq_fire;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            word_idx_q <= '0;
            fetched_q  <= '0;
            sent_q     <= '0;
            received_q <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            word_idx_q <= word_idx_d;
            fetched_q  <= fetched_d;
            sent_q     <= sent_d;
            received_q <= received_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

`ifdef QRACC_DATA_MASTER_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_empty_q, perf_empty_d;

    // Saturating counters, restarted when a job is accepted or aborted
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_empty_d = perf_empty_q;
        if (bus_valid_o && !bus_ready_i && perf_stall_q != '1) perf_stall_d = perf_stall_q + 1'b1;
        if (send_phase && fifo_empty && perf_empty_q != '1) perf_empty_d = perf_empty_q + 1'b1;
        if (clear_i || (state_q == S_IDLE && start_i)) begin
            perf_stall_d = '0;
            perf_empty_d = '0;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_stall_q <= '0;
            perf_empty_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_empty_q <= perf_empty_d;
        end
    end

    assign perf_bus_stall_o  = perf_stall_q;
    assign perf_fifo_empty_o = perf_empty_q;
`endif

endmodule

// File: tb/tb_qracc_data_master.sv
// tb_qracc_data_master: scoreboard bench for qracc_data_master with a 1-cycle-latency memory model
module tb_qracc_data_master;
    import qracc_pkg::*;

    logic        clk = 1'b0, nrst = 1'b0, start_i = 1'b0, clear_i = 1'b0;
    logic [15:0] src_base_i = '0, dst_base_i = '0;
    logic [15:0] n_weight_i = '0, n_act_i = '0, n_scaler_i = '0, n_out_i = '0;
    logic        busy_o, done_o, mem_rq_valid_o, mem_wr_en_o, bus_valid_o, bus_wen_o;
    logic        mem_rq_ready_i = 1'b1, mem_rd_valid_i = 1'b0;
    logic        bus_ready_i = 1'b1, bus_rd_data_valid_i = 1'b0;
    logic [15:0] mem_rq_addr_o, mem_wr_addr_o;
    logic [31:0] mem_rd_data_i = '0, mem_wr_data_o, bus_data_o, bus_rd_data_i = '0;
`ifdef QRACC_DATA_MASTER_PERF_EN
    logic [31:0] perf_bus_stall_o, perf_fifo_empty_o;
`endif

    int          checks = 0, errors = 0, dones = 0, outstanding = 0, peak = 0;
    logic [15:0] exp_addr = '0;
    logic        rand_ready = 1'b0;
    logic [31:0] bq[$];
    logic [47:0] wq[$];

    qracc_data_master dut (
        .clk                 (clk),
        .nrst                (nrst),
        .start_i             (start_i),
        .clear_i             (clear_i),
        .src_base_i          (src_base_i),
        .dst_base_i          (dst_base_i),
        .n_weight_i          (n_weight_i),
        .n_act_i             (n_act_i),
        .n_scaler_i          (n_scaler_i),
        .n_out_i             (n_out_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .mem_rq_valid_o      (mem_rq_valid_o),
        .mem_rq_ready_i      (mem_rq_ready_i),
        .mem_rq_addr_o       (mem_rq_addr_o),
        .mem_rd_data_i       (mem_rd_data_i),
        .mem_rd_valid_i      (mem_rd_valid_i),
        .mem_wr_en_o         (mem_wr_en_o),
        .mem_wr_addr_o       (mem_wr_addr_o),
        .mem_wr_data_o       (mem_wr_data_o),
        .bus_valid_o         (bus_valid_o),
        .bus_ready_i         (bus_ready_i),
        .bus_wen_o           (bus_wen_o),
        .bus_data_o          (bus_data_o),
        .bus_rd_data_i       (bus_rd_data_i),
        .bus_rd_data_valid_i (bus_rd_data_valid_i)
`ifdef QRACC_DATA_MASTER_PERF_EN
        ,
        .perf_bus_stall_o    (perf_bus_stall_o),
        .perf_fifo_empty_o   (perf_fifo_empty_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Source memory: answers every accepted request exactly one cycle later with mdata(addr)
    always @(posedge clk) begin
        mem_rd_valid_i <= mem_rq_valid_o && mem_rq_ready_i;
        mem_rd_data_i  <= (mem_rq_valid_o && mem_rq_ready_i) ? mdata(mem_rq_addr_o) : 32'h0;
        mem_rq_ready_i <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compares bus writes, memory writes and request addresses against the scoreboard
    always @(negedge clk) begin
        if (!nrst) begin
            outstanding = 0;
        end else begin
            if (outstanding >= 4) chk("rq_hold", mem_rq_valid_o, 1'b0);
            if (mem_rq_valid_o && mem_rq_ready_i) begin
                chk("rq_addr", mem_rq_addr_o, exp_addr);
                exp_addr++;
                outstanding++;
            end
            if (bus_valid_o && bus_ready_i && bus_wen_o) begin
                outstanding--;
                if (bq.size() == 0) chk("bus_extra", bq.size(), 1);
                else chk("bus_data", bus_data_o, bq.pop_front());
            end
            if (mem_wr_en_o) begin
                if (wq.size() == 0) chk("wr_extra", wq.size(), 1);
                else chk("mem_wr", {mem_wr_addr_o, mem_wr_data_o}, wq.pop_front());
            end
            if (outstanding > peak) peak = outstanding;
            if (clear_i) outstanding = 0;
            if (done_o) dones++;
        end
    end

    task automatic launch(input logic [15:0] src, dst, nw, na, ns, no);
        src_base_i = src;
        dst_base_i = dst;
        n_weight_i = nw;
        n_act_i    = na;
        n_scaler_i = ns;
        n_out_i    = no;
        for (int i = 0; i < int'(nw) + int'(na) + int'(ns); i++) bq.push_back(mdata(src + 16'(i)));
        exp_addr = src;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_rise", busy_o, 1'b1);
    endtask

    task automatic wait_done(input int exp_dones, input logic drop_start);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = done_o;
        end
        if (seen && drop_start) start_i = 1'b0;
        chk("done_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        chk("done_pulse", done_o, 1'b0);
        chk("busy_fall", busy_o, 1'b0);
        chk("done_cnt", dones, exp_dones);
        chk("bus_left", bq.size(), 0);
        chk("wr_left", wq.size(), 0);
    endtask

    initial begin
        logic        ok;
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_rq", mem_rq_valid_o, 1'b0);
        chk("rst_bus", bus_valid_o, 1'b0);
        chk("rst_wr", mem_wr_en_o, 1'b0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Plain stream 0x10..0x18
        launch(16'h10, 16'h0, 16'd4, 16'd3, 16'd2, 16'd0);
        wait_done(1, 1'b0);

        // Same job with the responder stalled: prefetch must stop at four words
        bus_ready_i = 1'b0;
        peak = 0;
        launch(16'h10, 16'h0, 16'd4, 16'd3, 16'd2, 16'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("stall_peak", peak, 4);
        chk("rq_stop", mem_rq_valid_o, 1'b0);
        bus_ready_i = 1'b1;
        wait_done(2, 1'b0);

        // Output drain: three spaced read responses, then a stray fourth one
        launch(16'h20, 16'h40, 16'd1, 16'd0, 16'd0, 16'd3);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = bus_valid_o && !bus_wen_o;
        end
        chk("rd_phase", ok, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin
                repeat (2) @(posedge clk);
                #1;
                chk("rd_hold", bus_valid_o, 1'b1);
            end
            d = 32'hA0B0_C000 + 32'(i * 17);
            bus_rd_data_valid_i = 1'b1;
            bus_rd_data_i = d;
            wq.push_back({16'h40 + 16'(i), d});
            @(posedge clk);
            #1;
            bus_rd_data_valid_i = 1'b0;
            bus_rd_data_i = '0;
        end
        wait_done(3, 1'b0);
        bus_rd_data_valid_i = 1'b1;
        bus_rd_data_i = 32'hDEAD_BEEF;
        #1;
        chk("stray_rd", mem_wr_en_o, 1'b0);
        @(posedge clk);
        #1;
        bus_rd_data_valid_i = 1'b0;

        // Empty act phase with address wrap and random memory backpressure
        rand_ready = 1'b1;
        launch(16'hFFFE, 16'h0, 16'd2, 16'd0, 16'd3, 16'd0);
        wait_done(4, 1'b0);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Abort in a cycle where a request is accepted, restart while its response lands
        launch(16'h80, 16'h0, 16'd8, 16'd0, 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (mem_rq_valid_o && mem_rq_ready_i) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("clr_rq_seen", ok, 1'b1);
        clear_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        start_i = 1'b0;
        bq.delete();
        chk("clr_busy", busy_o, 1'b0);
        chk("clr_bus", bus_valid_o, 1'b0);
        chk("clr_rq", mem_rq_valid_o, 1'b0);
        chk("clr_rsp", mem_rd_valid_i, 1'b1);
        launch(16'h200, 16'h0, 16'd3, 16'd2, 16'd1, 16'd0);
        chk("clr_empty", bus_valid_o, 1'b0);
        wait_done(5, 1'b0);

        // start_i held through the job and DONE, dropped before IDLE samples it
        launch(16'h300, 16'h0, 16'd2, 16'd2, 16'd2, 16'd0);
        start_i = 1'b1;
        wait_done(6, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_restart", busy_o, 1'b0);

        // Asynchronous reset mid-stream
        launch(16'h500, 16'h0, 16'd8, 16'd8, 16'd0, 16'd0);
        repeat (5) @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_bus", bus_valid_o, 1'b0);
        chk("arst_data", bus_data_o, 32'h0);
        chk("arst_rq", mem_rq_valid_o, 1'b0);
        chk("arst_wr", mem_wr_en_o, 1'b0);
        bq.delete();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        launch(16'h600, 16'h0, 16'd2, 16'd1, 16'd1, 16'd0);
        wait_done(7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
